// File: rtl/axi_fe_pkg.sv
// Shared types and constants for the AXI address front end.
package axi_fe_pkg;

  typedef enum logic [1:0] {
    FIXED = 2'd0,
    INCR  = 2'd1,
    WRAP  = 2'd2
  } burst_e;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WR_BURST = 2'd1,
    WR_RESP  = 2'd2,
    RD_BURST = 2'd3
  } state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam int         BEAT_BYTES  = 32;

  // A burst can be served natively only as FIXED/INCR at the full beat size.
  function automatic logic burst_legal(input logic [1:0] burst, input logic [3:0] size,
                                       input logic [3:0] shift);
    return ((burst == FIXED) || (burst == INCR)) && (size == shift);
  endfunction

endpackage

// File: rtl/axi_fe_burst_gen.sv
// Beat address and beat counter generator shared by the read and write bursts.
module axi_fe_burst_gen #(
  parameter int BEAT_BYTES = axi_fe_pkg::BEAT_BYTES
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_load,
  input  logic [31:0] i_addr,
  input  logic [7:0]  i_len,
  input  logic        i_fixed,
  input  logic        i_step,
  output logic [31:0] o_addr,
  output logic        o_last
);

  logic [31:0] r_addr;
  logic [7:0]  r_len;
  logic [7:0]  r_count;
  logic        r_fixed;

  // The address add wraps naturally at 2^32.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_addr  <= 32'd0;
      r_len   <= 8'd0;
      r_count <= 8'd0;
      r_fixed <= 1'b0;
    end else if (i_load) begin
      r_addr  <= i_addr;
      r_len   <= i_len;
      r_count <= 8'd0;
      r_fixed <= i_fixed;
    end else if (i_step) begin
      r_addr  <= r_fixed ? r_addr : (r_addr + 32'(BEAT_BYTES));
      r_count <= r_count + 8'd1;
    end
  end

  assign o_addr = r_addr;
  assign o_last = (r_count == r_len);

endmodule

// File: rtl/axi_addr_frontend.sv
// AXI AW/AR to per-beat native command front end, one burst in flight.
// Optional AXI_FE_RESP_ERR_EN: reject unsupported bursts (SLVERR on writes, drop reads).
module axi_addr_frontend #(
  parameter int ADDR_SHIFT = 5,
  parameter int BEAT_BYTES = axi_fe_pkg::BEAT_BYTES
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        axi_aw_valid,
  output logic        axi_aw_ready,
  input  logic [31:0] axi_aw_payload_addr,
  input  logic [1:0]  axi_aw_payload_burst,
  input  logic [7:0]  axi_aw_payload_len,
  input  logic [3:0]  axi_aw_payload_size,
  input  logic        axi_aw_payload_id,
  input  logic [1:0]  axi_aw_payload_lock,
  input  logic [2:0]  axi_aw_payload_prot,
  input  logic [3:0]  axi_aw_payload_cache,
  input  logic [3:0]  axi_aw_payload_qos,
  input  logic        axi_aw_first,
  input  logic        axi_aw_last,
  input  logic        axi_ar_valid,
  output logic        axi_ar_ready,
  input  logic [31:0] axi_ar_payload_addr,
  input  logic [1:0]  axi_ar_payload_burst,
  input  logic [7:0]  axi_ar_payload_len,
  input  logic [3:0]  axi_ar_payload_size,
  input  logic        axi_ar_payload_id,
  input  logic [1:0]  axi_ar_payload_lock,
  input  logic [2:0]  axi_ar_payload_prot,
  input  logic [3:0]  axi_ar_payload_cache,
  input  logic [3:0]  axi_ar_payload_qos,
  input  logic        axi_ar_first,
  input  logic        axi_ar_last,
  output logic        axi_b_valid,
  input  logic        axi_b_ready,
  output logic [1:0]  axi_b_payload_resp,
  output logic        axi_b_payload_id,
  output logic        axi_b_first,
  output logic        axi_b_last,
  output logic        native_cmd_valid,
  input  logic        native_cmd_ready,
  output logic        native_cmd_payload_we,
  output logic [31:0] native_cmd_payload_addr
);
  import axi_fe_pkg::*;

  state_e      r_state;
  logic        r_last_wr;
  logic [1:0]  r_resp;
  logic        r_id;
  logic        w_idle;
  logic        w_grant_wr;
  logic        w_aw_hs;
  logic        w_ar_hs;
  logic        w_cmd_hs;
  logic        w_last;
  logic [31:0] w_beat_addr;
  logic        w_unused;

  assign w_unused = ^{axi_aw_payload_lock, axi_aw_payload_prot, axi_aw_payload_cache,
                      axi_aw_payload_qos, axi_aw_first, axi_aw_last, axi_aw_payload_size,
                      axi_ar_payload_lock, axi_ar_payload_prot, axi_ar_payload_cache,
                      axi_ar_payload_qos, axi_ar_first, axi_ar_last, axi_ar_payload_size,
                      axi_ar_payload_id};

  // Write wins a tie unless it was the last channel granted.
  assign w_idle       = (r_state == IDLE) && !sys_rst;
  assign w_grant_wr   = axi_aw_valid && (!axi_ar_valid || !r_last_wr);
  assign axi_aw_ready = w_idle && w_grant_wr;
  assign axi_ar_ready = w_idle && axi_ar_valid && !w_grant_wr;
  assign w_aw_hs      = axi_aw_valid && axi_aw_ready;
  assign w_ar_hs      = axi_ar_valid && axi_ar_ready;
  assign w_cmd_hs     = native_cmd_valid && native_cmd_ready;

`ifdef AXI_FE_RESP_ERR_EN
  logic w_aw_legal;
  logic w_ar_legal;
  assign w_aw_legal = burst_legal(axi_aw_payload_burst, axi_aw_payload_size, 4'(ADDR_SHIFT));
  assign w_ar_legal = burst_legal(axi_ar_payload_burst, axi_ar_payload_size, 4'(ADDR_SHIFT));
`endif

  axi_fe_burst_gen #(.BEAT_BYTES(BEAT_BYTES)) u_burst_gen (
    .i_clk   (sys_clk),
    .i_rst   (sys_rst),
    .i_load  (w_aw_hs || w_ar_hs),
    .i_addr  (w_aw_hs ? axi_aw_payload_addr : axi_ar_payload_addr),
    .i_len   (w_aw_hs ? axi_aw_payload_len : axi_ar_payload_len),
    .i_fixed (w_aw_hs ? (burst_e'(axi_aw_payload_burst) == FIXED)
                      : (burst_e'(axi_ar_payload_burst) == FIXED)),
    .i_step  (w_cmd_hs),
    .o_addr  (w_beat_addr),
    .o_last  (w_last)
  );

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_state   <= IDLE;
      r_last_wr <= 1'b0;
      r_resp    <= RESP_OKAY;
      r_id      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_aw_hs) begin
            r_last_wr <= 1'b1;
            r_id      <= axi_aw_payload_id;
`ifdef AXI_FE_RESP_ERR_EN
            r_state   <= w_aw_legal ? WR_BURST : WR_RESP;
            r_resp    <= w_aw_legal ? RESP_OKAY : RESP_SLVERR;
`else
            r_state   <= WR_BURST;
            r_resp    <= RESP_OKAY;
`endif
          end else if (w_ar_hs) begin
            r_last_wr <= 1'b0;
`ifdef AXI_FE_RESP_ERR_EN
            r_state   <= w_ar_legal ? RD_BURST : IDLE;
`else
            r_state   <= RD_BURST;
`endif
          end
        end
        WR_BURST: if (w_cmd_hs && w_last) r_state <= WR_RESP;
        WR_RESP:  if (axi_b_ready) r_state <= IDLE;
        RD_BURST: if (w_cmd_hs && w_last) r_state <= IDLE;
        default:  r_state <= IDLE;
      endcase
    end
  end

  assign axi_b_valid             = (r_state == WR_RESP);
  assign axi_b_first             = axi_b_valid;
  assign axi_b_last              = axi_b_valid;
  assign axi_b_payload_resp      = r_resp;
  assign axi_b_payload_id        = r_id;
  assign native_cmd_valid        = (r_state == WR_BURST) || (r_state == RD_BURST);
  assign native_cmd_payload_we   = (r_state == WR_BURST);
  assign native_cmd_payload_addr = w_beat_addr >> ADDR_SHIFT;

endmodule

// File: tb/tb_axi_addr_frontend.sv
// Directed self-checking bench for axi_addr_frontend.
module tb_axi_addr_frontend;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic        axi_aw_valid, axi_aw_ready, axi_aw_payload_id;
  logic [31:0] axi_aw_payload_addr;
  logic [1:0]  axi_aw_payload_burst;
  logic [7:0]  axi_aw_payload_len;
  logic [3:0]  axi_aw_payload_size;
  logic        axi_ar_valid, axi_ar_ready, axi_ar_payload_id;
  logic [31:0] axi_ar_payload_addr;
  logic [1:0]  axi_ar_payload_burst;
  logic [7:0]  axi_ar_payload_len;
  logic [3:0]  axi_ar_payload_size;
  logic        axi_b_valid, axi_b_ready, axi_b_payload_id, axi_b_first, axi_b_last;
  logic [1:0]  axi_b_payload_resp;
  logic        native_cmd_valid, native_cmd_ready, native_cmd_payload_we;
  logic [31:0] native_cmd_payload_addr;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int b_hs_cyc = 0;
  int ar_hs_cyc = 0;
  logic [32:0] cmd_q[$];
  logic [4:0]  b_q[$];

  always #5 sys_clk = ~sys_clk;

  axi_addr_frontend dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .axi_aw_valid(axi_aw_valid), .axi_aw_ready(axi_aw_ready),
    .axi_aw_payload_addr(axi_aw_payload_addr), .axi_aw_payload_burst(axi_aw_payload_burst),
    .axi_aw_payload_len(axi_aw_payload_len), .axi_aw_payload_size(axi_aw_payload_size),
    .axi_aw_payload_id(axi_aw_payload_id), .axi_aw_payload_lock(2'b00),
    .axi_aw_payload_prot(3'b000), .axi_aw_payload_cache(4'h0), .axi_aw_payload_qos(4'h0),
    .axi_aw_first(1'b0), .axi_aw_last(1'b0),
    .axi_ar_valid(axi_ar_valid), .axi_ar_ready(axi_ar_ready),
    .axi_ar_payload_addr(axi_ar_payload_addr), .axi_ar_payload_burst(axi_ar_payload_burst),
    .axi_ar_payload_len(axi_ar_payload_len), .axi_ar_payload_size(axi_ar_payload_size),
    .axi_ar_payload_id(axi_ar_payload_id), .axi_ar_payload_lock(2'b00),
    .axi_ar_payload_prot(3'b000), .axi_ar_payload_cache(4'h0), .axi_ar_payload_qos(4'h0),
    .axi_ar_first(1'b0), .axi_ar_last(1'b0),
    .axi_b_valid(axi_b_valid), .axi_b_ready(axi_b_ready),
    .axi_b_payload_resp(axi_b_payload_resp), .axi_b_payload_id(axi_b_payload_id),
    .axi_b_first(axi_b_first), .axi_b_last(axi_b_last),
    .native_cmd_valid(native_cmd_valid), .native_cmd_ready(native_cmd_ready),
    .native_cmd_payload_we(native_cmd_payload_we), .native_cmd_payload_addr(native_cmd_payload_addr)
  );

  // Handshake recorder, sampled mid-cycle.
  always @(negedge sys_clk) begin
    cyc = cyc + 1;
    if (native_cmd_valid && native_cmd_ready)
      cmd_q.push_back({native_cmd_payload_we, native_cmd_payload_addr});
    if (axi_b_valid && axi_b_ready) begin
      b_q.push_back({axi_b_payload_resp, axi_b_payload_id, axi_b_first, axi_b_last});
      b_hs_cyc = cyc;
    end
    if (axi_ar_valid && axi_ar_ready) ar_hs_cyc = cyc;
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge sys_clk); #1;
    end
  endtask

  task automatic drive_aw(input logic [31:0] a, input logic [7:0] l, input logic [1:0] b,
                          input logic id, output bit ok);
    axi_aw_payload_addr = a; axi_aw_payload_len = l; axi_aw_payload_burst = b;
    axi_aw_payload_id = id; axi_aw_payload_size = 4'd5; axi_aw_valid = 1'b1; ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge sys_clk);
      if (axi_aw_ready) begin ok = 1'b1; break; end
    end
    @(posedge sys_clk); #1; axi_aw_valid = 1'b0;
  endtask

  task automatic drive_ar(input logic [31:0] a, input logic [7:0] l, input logic [1:0] b,
                          output bit ok);
    axi_ar_payload_addr = a; axi_ar_payload_len = l; axi_ar_payload_burst = b;
    axi_ar_payload_id = 1'b0; axi_ar_payload_size = 4'd5; axi_ar_valid = 1'b1; ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge sys_clk);
      if (axi_ar_ready) begin ok = 1'b1; break; end
    end
    @(posedge sys_clk); #1; axi_ar_valid = 1'b0;
  endtask

  task automatic apply_reset();
    sys_rst = 1'b1;
    tick(3);
    sys_rst = 1'b0;
    tick(1);
  endtask

  task automatic test_reset();
    sys_rst = 1'b1; axi_aw_valid = 1'b1; axi_ar_valid = 1'b1;
    tick(2);
    @(negedge sys_clk);
    total++;
    if ({axi_aw_ready, axi_ar_ready, native_cmd_valid, axi_b_valid, axi_b_payload_resp, axi_b_payload_id} !== 7'd0) begin
      bad++;
      $display("FAIL reset_outputs: got aw_rdy=%b ar_rdy=%b cmd_v=%b b_v=%b resp=%b id=%b, want all 0",
               axi_aw_ready, axi_ar_ready, native_cmd_valid, axi_b_valid, axi_b_payload_resp, axi_b_payload_id);
    end
    @(posedge sys_clk); #1;
    axi_aw_valid = 1'b0; axi_ar_valid = 1'b0; sys_rst = 1'b0;
    tick(1);
  endtask

  task automatic test_incr_write();
    bit ok;
    logic [31:0] exp_a [4] = '{32'h80, 32'h81, 32'h82, 32'h83};
    cmd_q.delete(); b_q.delete();
    native_cmd_ready = 1'b1; axi_b_ready = 1'b1;
    drive_aw(32'h1000, 8'd3, 2'd1, 1'b1, ok);
    total++;
    if (!ok || native_cmd_valid !== 1'b1 || native_cmd_payload_addr !== 32'h80) begin
      bad++;
      $display("FAIL incr_first_cmd: ok=%b valid=%b addr=%h, want 1 1 00000080", ok, native_cmd_valid, native_cmd_payload_addr);
    end
    tick(10);
    total++;
    if (cmd_q.size() != 4) begin
      bad++; $display("FAIL incr_cmd_count: got %0d want 4", cmd_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        total++;
        if (cmd_q[i] !== {1'b1, exp_a[i]}) begin
          bad++; $display("FAIL incr_cmd%0d: got %h want %h", i, cmd_q[i], {1'b1, exp_a[i]});
        end
      end
    end
    total++;
    if (b_q.size() != 1 || b_q[0] !== 5'b00_1_1_1) begin
      bad++; $display("FAIL incr_b: got n=%0d rec=%b want n=1 rec=00111", b_q.size(), (b_q.size() > 0) ? b_q[0] : 5'h1f);
    end
  endtask

  task automatic test_fixed_read();
    bit ok;
    cmd_q.delete(); b_q.delete();
    drive_ar(32'h40, 8'd0, 2'd0, ok);
    tick(8);
    total++;
    if (!ok || cmd_q.size() != 1 || cmd_q[0] !== {1'b0, 32'h2}) begin
      bad++; $display("FAIL fixed_read: ok=%b n=%0d first=%h want 1 1 000000002", ok, cmd_q.size(), (cmd_q.size() > 0) ? cmd_q[0] : 33'h0);
    end
    total++;
    if (b_q.size() != 0) begin
      bad++; $display("FAIL fixed_read_no_b: got %0d B want 0", b_q.size());
    end
  endtask

  task automatic test_arbitration();
    int ar_seen = 0;
    bit ok;
    apply_reset();
    cmd_q.delete(); b_q.delete();
    native_cmd_ready = 1'b1; axi_b_ready = 1'b0;
    axi_aw_payload_addr = 32'h2000; axi_aw_payload_len = 8'd1; axi_aw_payload_burst = 2'd1;
    axi_aw_payload_id = 1'b0; axi_aw_payload_size = 4'd5;
    axi_ar_payload_addr = 32'h3000; axi_ar_payload_len = 8'd0; axi_ar_payload_burst = 2'd1;
    axi_ar_payload_size = 4'd5;
    axi_aw_valid = 1'b1; axi_ar_valid = 1'b1;
    @(negedge sys_clk);
    total++;
    if (axi_aw_ready !== 1'b1 || axi_ar_ready !== 1'b0) begin
      bad++; $display("FAIL arb_tie_after_reset: aw_rdy=%b ar_rdy=%b want 1 0", axi_aw_ready, axi_ar_ready);
    end
    @(posedge sys_clk); #1; axi_aw_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge sys_clk);
      if (axi_ar_ready) ar_seen++;
      @(posedge sys_clk); #1;
    end
    total++;
    if (ar_seen != 0 || axi_b_valid !== 1'b1) begin
      bad++; $display("FAIL arb_hold_ar: ar_rdy cycles=%0d b_valid=%b want 0 1", ar_seen, axi_b_valid);
    end
    axi_b_ready = 1'b1;
    drive_ar(32'h3000, 8'd0, 2'd1, ok);
    tick(4);
    total++;
    if (!ok || cmd_q.size() != 3 || cmd_q[0] !== {1'b1, 32'h100} || cmd_q[1] !== {1'b1, 32'h101}
        || cmd_q[2] !== {1'b0, 32'h180} || ar_hs_cyc <= b_hs_cyc) begin
      bad++; $display("FAIL arb_order: ok=%b n=%0d ar_cyc=%0d b_cyc=%0d want W100 W101 R180 with ar after b",
                      ok, cmd_q.size(), ar_hs_cyc, b_hs_cyc);
    end
  endtask

  task automatic test_round_robin();
    bit ok;
    drive_aw(32'h0, 8'd0, 2'd1, 1'b0, ok);
    tick(5);
    cmd_q.delete();
    axi_aw_payload_addr = 32'h20; axi_ar_payload_addr = 32'h60;
    axi_aw_payload_len = 8'd0; axi_ar_payload_len = 8'd0;
    axi_aw_valid = 1'b1; axi_ar_valid = 1'b1;
    @(negedge sys_clk);
    total++;
    if (axi_ar_ready !== 1'b1 || axi_aw_ready !== 1'b0) begin
      bad++; $display("FAIL rr_read_turn: aw_rdy=%b ar_rdy=%b want 0 1", axi_aw_ready, axi_ar_ready);
    end
    @(posedge sys_clk); #1; axi_ar_valid = 1'b0;
    drive_aw(32'h20, 8'd0, 2'd1, 1'b0, ok);
    tick(5);
    total++;
    if (cmd_q.size() != 2 || cmd_q[0] !== {1'b0, 32'h3} || cmd_q[1] !== {1'b1, 32'h1}) begin
      bad++; $display("FAIL rr_order: n=%0d first=%h want R3 then W1", cmd_q.size(), (cmd_q.size() > 0) ? cmd_q[0] : 33'h0);
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    cmd_q.delete(); b_q.delete();
    axi_b_ready = 1'b0; native_cmd_ready = 1'b0;
    drive_aw(32'h0, 8'd3, 2'd1, 1'b1, ok);
    for (int i = 0; i < 40; i++) begin
      if (axi_b_valid) break;
      native_cmd_ready = ~native_cmd_ready;
      @(posedge sys_clk); #1;
    end
    native_cmd_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge sys_clk);
      total++;
      if ({axi_b_valid, axi_b_payload_resp, axi_b_payload_id, axi_b_first, axi_b_last} !== 6'b1_00_1_1_1) begin
        bad++; $display("FAIL b_stable%0d: v=%b resp=%b id=%b f=%b l=%b want 1 00 1 1 1", i,
                        axi_b_valid, axi_b_payload_resp, axi_b_payload_id, axi_b_first, axi_b_last);
      end
    end
    @(posedge sys_clk); #1; axi_b_ready = 1'b1;
    tick(2);
    total++;
    if (axi_b_valid !== 1'b0 || b_q.size() != 1) begin
      bad++; $display("FAIL b_release: v=%b n=%0d want 0 1", axi_b_valid, b_q.size());
    end
    total++;
    if (cmd_q.size() != 4 || cmd_q[0] !== {1'b1, 32'h0} || cmd_q[1] !== {1'b1, 32'h1}
        || cmd_q[2] !== {1'b1, 32'h2} || cmd_q[3] !== {1'b1, 32'h3}) begin
      bad++; $display("FAIL stall_cmds: n=%0d want W0 W1 W2 W3", cmd_q.size());
    end
  endtask

  task automatic test_addr_wrap();
    bit ok;
    cmd_q.delete();
    drive_aw(32'hFFFF_FFE0, 8'd1, 2'd1, 1'b0, ok);
    tick(6);
    total++;
    if (cmd_q.size() != 2 || cmd_q[0] !== {1'b1, 32'h07FF_FFFF} || cmd_q[1] !== {1'b1, 32'h0}) begin
      bad++; $display("FAIL addr_wrap: n=%0d second=%h want W07ffffff then W00000000", cmd_q.size(),
                      (cmd_q.size() > 1) ? cmd_q[1] : 33'h0);
    end
  endtask

  task automatic test_wrap_burst();
    bit ok;
    cmd_q.delete(); b_q.delete();
    drive_aw(32'h100, 8'd1, 2'd2, 1'b1, ok);
    tick(6);
`ifdef AXI_FE_RESP_ERR_EN
    total++;
    if (cmd_q.size() != 0 || b_q.size() != 1 || b_q[0] !== 5'b10_1_1_1) begin
      bad++; $display("FAIL wrap_slverr: n_cmd=%0d n_b=%0d want 0 cmds and B resp=10 id=1", cmd_q.size(), b_q.size());
    end
`else
    total++;
    if (cmd_q.size() != 2 || cmd_q[0] !== {1'b1, 32'h8} || cmd_q[1] !== {1'b1, 32'h9}
        || b_q.size() != 1 || b_q[0] !== 5'b00_1_1_1) begin
      bad++; $display("FAIL wrap_as_incr: n_cmd=%0d n_b=%0d want W8 W9 and B resp=00 id=1", cmd_q.size(), b_q.size());
    end
`endif
  endtask

  task automatic test_reset_mid_burst();
    bit ok;
    cmd_q.delete(); b_q.delete();
    native_cmd_ready = 1'b0;
    drive_aw(32'h400, 8'd7, 2'd1, 1'b1, ok);
    tick(3);
    total++;
    if (native_cmd_valid !== 1'b1) begin
      bad++; $display("FAIL midburst_stalled: valid=%b want 1", native_cmd_valid);
    end
    sys_rst = 1'b1;
    tick(2);
    sys_rst = 1'b0;
    native_cmd_ready = 1'b1;
    tick(10);
    total++;
    if (native_cmd_valid !== 1'b0 || axi_b_valid !== 1'b0 || cmd_q.size() != 0 || b_q.size() != 0) begin
      bad++; $display("FAIL midburst_abandon: cmd_v=%b b_v=%b n_cmd=%0d n_b=%0d want all 0",
                      native_cmd_valid, axi_b_valid, cmd_q.size(), b_q.size());
    end
  endtask

  initial begin
    sys_rst = 1'b1;
    axi_aw_valid = 1'b0; axi_aw_payload_addr = 32'h0; axi_aw_payload_burst = 2'd1;
    axi_aw_payload_len = 8'd0; axi_aw_payload_size = 4'd5; axi_aw_payload_id = 1'b0;
    axi_ar_valid = 1'b0; axi_ar_payload_addr = 32'h0; axi_ar_payload_burst = 2'd1;
    axi_ar_payload_len = 8'd0; axi_ar_payload_size = 4'd5; axi_ar_payload_id = 1'b0;
    axi_b_ready = 1'b1; native_cmd_ready = 1'b1;
    @(posedge sys_clk); #1;
    test_reset();
    test_incr_write();
    test_fixed_read();
    test_arbitration();
    test_round_robin();
    test_backpressure();
    test_addr_wrap();
    test_wrap_burst();
    test_reset_mid_burst();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1);
  end

endmodule
